// File: rtl/alu_rs.sv
// Integer ALU reservation station: dispatch into free entries, wake operands from the ALU/LSB
// broadcast buses, issue one ready entry per cycle. ALU_RS_OLDEST_FIRST_EN selects oldest-first issue.
module alu_rs #(
  parameter int RS_SIZE     = 16,
  parameter int OPCODE_WID  = 7,
  parameter int FUNCT3_WID  = 3,
  parameter int DATA_WID    = 32,
  parameter int ADDR_WID    = 32,
  parameter int ROB_POS_WID = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  output logic                   rs_full,
  input  logic                   disp_en,
  input  logic [OPCODE_WID-1:0]  disp_opcode,
  input  logic [FUNCT3_WID-1:0]  disp_funct3,
  input  logic                   disp_funct7,
  input  logic [DATA_WID-1:0]    disp_val1,
  input  logic [DATA_WID-1:0]    disp_val2,
  input  logic                   disp_has_dep1,
  input  logic                   disp_has_dep2,
  input  logic [ROB_POS_WID-1:0] disp_dep1,
  input  logic [ROB_POS_WID-1:0] disp_dep2,
  input  logic [DATA_WID-1:0]    disp_imm,
  input  logic [ADDR_WID-1:0]    disp_pc,
  input  logic [ROB_POS_WID-1:0] disp_rob_pos,
  input  logic                   alu_result,
  input  logic [ROB_POS_WID-1:0] alu_result_rob_pos,
  input  logic [DATA_WID-1:0]    alu_result_val,
  input  logic                   lsb_result,
  input  logic [ROB_POS_WID-1:0] lsb_result_rob_pos,
  input  logic [DATA_WID-1:0]    lsb_result_val,
  output logic                   alu_en,
  output logic [OPCODE_WID-1:0]  alu_opcode,
  output logic [FUNCT3_WID-1:0]  alu_funct3,
  output logic                   alu_funct7,
  output logic [DATA_WID-1:0]    alu_val1,
  output logic [DATA_WID-1:0]    alu_val2,
  output logic [DATA_WID-1:0]    alu_imm,
  output logic [ADDR_WID-1:0]    alu_pc,
  output logic [ROB_POS_WID-1:0] alu_rob_pos
);

  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic                   has_dep;
    logic [ROB_POS_WID-1:0] tag;
    logic [DATA_WID-1:0]    val;
  } opnd_t;

  typedef struct packed {
    logic [OPCODE_WID-1:0]  opcode;
    logic [FUNCT3_WID-1:0]  funct3;
    logic                   funct7;
    logic [DATA_WID-1:0]    imm;
    logic [ADDR_WID-1:0]    pc;
    logic [ROB_POS_WID-1:0] rob_pos;
    opnd_t                  op1;
    opnd_t                  op2;
  } entry_t;

  // Resolve a pending operand against this cycle's broadcasts; the ALU bus wins a double match.
  function automatic opnd_t wake(input opnd_t o);
    opnd_t r;
    r = o;
    if (o.has_dep) begin
      if (alu_result && alu_result_rob_pos == o.tag) begin
        r.has_dep = 1'b0;
        r.val     = alu_result_val;
      end else if (lsb_result && lsb_result_rob_pos == o.tag) begin
        r.has_dep = 1'b0;
        r.val     = lsb_result_val;
      end
    end
    return r;
  endfunction

  logic [RS_SIZE-1:0] busy_vec;
  logic [RS_SIZE-1:0] ready_vec;
  logic [RS_SIZE-1:0] cand_vec;
  entry_t             ent [RS_SIZE];
  entry_t             disp_ent;
  opnd_t              disp_op1;
  opnd_t              disp_op2;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               disp_fire;
  logic               issue;

  assign rs_full   = &busy_vec;
  assign disp_fire = disp_en && !rs_full;

  always_comb begin
    disp_op1         = wake('{has_dep: disp_has_dep1, tag: disp_dep1, val: disp_val1});
    disp_op2         = wake('{has_dep: disp_has_dep2, tag: disp_dep2, val: disp_val2});
    disp_ent.opcode  = disp_opcode;
    disp_ent.funct3  = disp_funct3;
    disp_ent.funct7  = disp_funct7;
    disp_ent.imm     = disp_imm;
    disp_ent.pc      = disp_pc;
    disp_ent.rob_pos = disp_rob_pos;
    disp_ent.op1     = disp_op1;
    disp_ent.op2     = disp_op2;
  end

  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_vec[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (cand_vec[i]) sel_idx = IDX_W'(i);
    end
  end
  assign issue = |cand_vec;

`ifdef ALU_RS_OLDEST_FIRST_EN
  // age_mat[i][j] = 1 means entry i was dispatched before entry j.
  logic [RS_SIZE-1:0][RS_SIZE-1:0] age_mat;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_ent
      logic   busy_reg;
      entry_t ent_reg;

      always_ff @(posedge clk) begin
        if (rst || rollback) begin
          busy_reg <= 1'b0;
        end else if (rdy) begin
          if (issue && sel_idx == IDX_W'(gi)) begin
            busy_reg <= 1'b0;
          end else if (disp_fire && free_idx == IDX_W'(gi)) begin
            busy_reg <= 1'b1;
            ent_reg  <= disp_ent;
          end else if (busy_reg) begin
            ent_reg.op1 <= wake(ent_reg.op1);
            ent_reg.op2 <= wake(ent_reg.op2);
          end
        end
      end

      assign busy_vec[gi]  = busy_reg;
      assign ready_vec[gi] = busy_reg && !ent_reg.op1.has_dep && !ent_reg.op2.has_dep;
      assign ent[gi]       = ent_reg;

`ifdef ALU_RS_OLDEST_FIRST_EN
      logic [RS_SIZE-1:0] age_row_reg;
      logic               blocked;

      // A newly dispatched entry is younger than everything still resident.
      always_ff @(posedge clk) begin
        if (rst || rollback) begin
          age_row_reg <= '0;
        end else if (rdy) begin
          if (disp_fire && free_idx == IDX_W'(gi)) begin
            age_row_reg <= '0;
          end else if (issue && sel_idx == IDX_W'(gi)) begin
            age_row_reg <= '0;
          end else begin
            if (disp_fire && busy_reg) age_row_reg[free_idx] <= 1'b1;
            if (issue) age_row_reg[sel_idx] <= 1'b0;
          end
        end
      end

      assign age_mat[gi] = age_row_reg;

      always_comb begin
        blocked = 1'b0;
        for (int j = 0; j < RS_SIZE; j++) begin
          if (ready_vec[j] && age_mat[j][gi]) blocked = 1'b1;
        end
      end

      assign cand_vec[gi] = ready_vec[gi] && !blocked;
`else
      assign cand_vec[gi] = ready_vec[gi];
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_en      <= 1'b0;
      alu_opcode  <= '0;
      alu_funct3  <= '0;
      alu_funct7  <= 1'b0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
    end else if (rollback) begin
      alu_en <= 1'b0;
    end else if (rdy) begin
      alu_en <= issue;
      if (issue) begin
        alu_opcode  <= ent[sel_idx].opcode;
        alu_funct3  <= ent[sel_idx].funct3;
        alu_funct7  <= ent[sel_idx].funct7;
        alu_val1    <= ent[sel_idx].op1.val;
        alu_val2    <= ent[sel_idx].op2.val;
        alu_imm     <= ent[sel_idx].imm;
        alu_pc      <= ent[sel_idx].pc;
        alu_rob_pos <= ent[sel_idx].rob_pos;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed testbench for alu_rs: issue latency, wakeup/forwarding, full/drop, ordering, rollback, stall.
module tb_alu_rs;
  logic        clk, rst, rdy, rollback, rs_full;
  logic        disp_en;
  logic [6:0]  disp_opcode;
  logic [2:0]  disp_funct3;
  logic        disp_funct7;
  logic [31:0] disp_val1, disp_val2, disp_imm, disp_pc;
  logic        disp_has_dep1, disp_has_dep2;
  logic [3:0]  disp_dep1, disp_dep2, disp_rob_pos;
  logic        alu_result, lsb_result;
  logic [3:0]  alu_result_rob_pos, lsb_result_rob_pos;
  logic [31:0] alu_result_val, lsb_result_val;
  logic        alu_en;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;

  int total_cnt = 0;
  int pass_cnt  = 0;

  localparam logic [6:0] OP_ADD = 7'b0110011;

  alu_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rs_full(rs_full),
    .disp_en(disp_en), .disp_opcode(disp_opcode), .disp_funct3(disp_funct3),
    .disp_funct7(disp_funct7), .disp_val1(disp_val1), .disp_val2(disp_val2),
    .disp_has_dep1(disp_has_dep1), .disp_has_dep2(disp_has_dep2),
    .disp_dep1(disp_dep1), .disp_dep2(disp_dep2), .disp_imm(disp_imm),
    .disp_pc(disp_pc), .disp_rob_pos(disp_rob_pos),
    .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
    .alu_result_val(alu_result_val), .lsb_result(lsb_result),
    .lsb_result_rob_pos(lsb_result_rob_pos), .lsb_result_val(lsb_result_val),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_funct3(alu_funct3),
    .alu_funct7(alu_funct7), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_disp(input logic [31:0] v1, input logic [31:0] v2,
                          input logic hd1, input logic [3:0] d1,
                          input logic hd2, input logic [3:0] d2, input logic [3:0] rob);
    disp_en       = 1'b1;
    disp_opcode   = OP_ADD;
    disp_funct3   = 3'd0;
    disp_funct7   = 1'b0;
    disp_val1     = v1;
    disp_val2     = v2;
    disp_has_dep1 = hd1;
    disp_dep1     = d1;
    disp_has_dep2 = hd2;
    disp_dep2     = d2;
    disp_rob_pos  = rob;
    disp_imm      = 32'h100 + 32'(rob);
    disp_pc       = 32'h1000 + 32'(rob);
  endtask

  task automatic clr_bus();
    disp_en    = 1'b0;
    alu_result = 1'b0;
    lsb_result = 1'b0;
    rollback   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    disp_en = 1'b0; disp_opcode = '0; disp_funct3 = '0; disp_funct7 = 1'b0;
    disp_val1 = '0; disp_val2 = '0; disp_has_dep1 = 1'b0; disp_has_dep2 = 1'b0;
    disp_dep1 = '0; disp_dep2 = '0; disp_imm = '0; disp_pc = '0; disp_rob_pos = '0;
    alu_result = 1'b0; alu_result_rob_pos = '0; alu_result_val = '0;
    lsb_result = 1'b0; lsb_result_rob_pos = '0; lsb_result_val = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_alu_en", alu_en, 0);
    check("rst_val1", alu_val1, 0);
    check("rst_rob", alu_rob_pos, 0);
    check("rst_full", rs_full, 0);

    // Ready ADD: dispatch at edge 1, issue at edge 2
    set_disp(32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6);
    tick(); clr_bus();
    check("add_wait", alu_en, 0);
    tick();
    check("add_en", alu_en, 1);
    check("add_val1", alu_val1, 5);
    check("add_val2", alu_val2, 7);
    check("add_rob", alu_rob_pos, 6);
    check("add_imm", alu_imm, 32'h106);
    check("add_pc", alu_pc, 32'h1006);
    check("add_op", alu_opcode, OP_ADD);
    tick();
    check("add_done", alu_en, 0);

    // LSB wakeup of operand 1
    set_disp(32'd0, 32'd1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd4);
    tick(); clr_bus();
    check("lsbw_wait0", alu_en, 0);
    tick();
    check("lsbw_wait1", alu_en, 0);
    lsb_result = 1'b1; lsb_result_rob_pos = 4'd3; lsb_result_val = 32'h1234;
    tick(); clr_bus();
    check("lsbw_wait2", alu_en, 0);
    tick();
    check("lsbw_en", alu_en, 1);
    check("lsbw_val1", alu_val1, 32'h1234);
    check("lsbw_rob", alu_rob_pos, 4);

    // Dispatch-cycle forwarding from the ALU bus into operand 2
    set_disp(32'd2, 32'd0, 1'b0, 4'd0, 1'b1, 4'd9, 4'd5);
    alu_result = 1'b1; alu_result_rob_pos = 4'd9; alu_result_val = 32'hFF;
    tick(); clr_bus();
    check("fwd_wait", alu_en, 0);
    tick();
    check("fwd_en", alu_en, 1);
    check("fwd_val2", alu_val2, 32'hFF);
    check("fwd_rob", alu_rob_pos, 5);
    tick();
    check("fwd_done", alu_en, 0);

    // Fill all entries with pending ops; entry i waits on tag i
    for (int i = 0; i < 16; i++) begin
      set_disp(32'd0, 32'(i), 1'b1, 4'(i), 1'b0, 4'd0, 4'(i));
      tick();
      if (i == 14) check("full_at15", rs_full, 0);
    end
    clr_bus();
    check("full_at16", rs_full, 1);
    set_disp(32'hDEAD, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd14);
    tick(); clr_bus();
    check("drop_en0", alu_en, 0);
    tick();
    check("drop_en1", alu_en, 0);
    alu_result = 1'b1; alu_result_rob_pos = 4'd10; alu_result_val = 32'hAA;
    tick(); clr_bus();
    check("full_wake", rs_full, 1);
    check("e10_wait", alu_en, 0);
    tick();
    check("e10_en", alu_en, 1);
    check("e10_rob", alu_rob_pos, 10);
    check("e10_val1", alu_val1, 32'hAA);
    check("e10_val2", alu_val2, 10);
    check("e10_notfull", rs_full, 0);
    tick();
    check("e10_once", alu_en, 0);
    rollback = 1'b1;
    tick(); clr_bus();
    check("clr_full", rs_full, 0);

    // Issue order: A(e0) pending, B(e1) pending, A wakes and issues, C(e0) ready + B wakes
    set_disp(32'd0, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0, 4'd1);
    tick();
    set_disp(32'd0, 32'd0, 1'b1, 4'd6, 1'b0, 4'd0, 4'd2);
    tick(); clr_bus();
    alu_result = 1'b1; alu_result_rob_pos = 4'd2; alu_result_val = 32'h22;
    tick(); clr_bus();
    tick();
    check("ord_a_en", alu_en, 1);
    check("ord_a_rob", alu_rob_pos, 1);
    check("ord_a_val1", alu_val1, 32'h22);
    set_disp(32'd3, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    lsb_result = 1'b1; lsb_result_rob_pos = 4'd6; lsb_result_val = 32'h66;
    tick(); clr_bus();
    check("ord_gap", alu_en, 0);
    tick();
    check("ord_1_en", alu_en, 1);
`ifdef ALU_RS_OLDEST_FIRST_EN
    check("ord_1_rob", alu_rob_pos, 2);
`else
    check("ord_1_rob", alu_rob_pos, 3);
`endif
    tick();
    check("ord_2_en", alu_en, 1);
`ifdef ALU_RS_OLDEST_FIRST_EN
    check("ord_2_rob", alu_rob_pos, 3);
`else
    check("ord_2_rob", alu_rob_pos, 2);
`endif
    tick();
    check("ord_idle", alu_en, 0);

    // Rollback with 4 pending entries while alu_en is high
    for (int i = 0; i < 4; i++) begin
      set_disp(32'd0, 32'd0, 1'b1, 4'd7, 1'b0, 4'd0, 4'(8 + i));
      tick();
    end
    set_disp(32'd12, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12);
    tick(); clr_bus();
    tick();
    check("rb_pre_en", alu_en, 1);
    check("rb_pre_rob", alu_rob_pos, 12);
    rollback = 1'b1;
    set_disp(32'd13, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13);
    alu_result = 1'b1; alu_result_rob_pos = 4'd7; alu_result_val = 32'h77;
    tick(); clr_bus();
    check("rb_en", alu_en, 0);
    check("rb_full", rs_full, 0);
    alu_result = 1'b1; alu_result_rob_pos = 4'd7; alu_result_val = 32'h78;
    tick(); clr_bus();
    for (int i = 0; i < 3; i++) begin
      check("rb_stale", alu_en, 0);
      tick();
    end

    // Stall with rdy low: outputs frozen, broadcasts and dispatch ignored
    set_disp(32'd21, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
    tick();
    set_disp(32'd22, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
    tick();
    check("st_p1_rob", alu_rob_pos, 1);
    set_disp(32'd0, 32'd0, 1'b1, 4'd5, 1'b0, 4'd0, 4'd3);
    tick();
    check("st_p2_rob", alu_rob_pos, 2);
    rdy = 1'b0;
    set_disp(32'd24, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
    alu_result = 1'b1; alu_result_rob_pos = 4'd5; alu_result_val = 32'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_frz_en", alu_en, 1);
      check("st_frz_rob", alu_rob_pos, 2);
      check("st_frz_val1", alu_val1, 22);
    end
    rdy = 1'b1; clr_bus();
    tick();
    check("st_res_en0", alu_en, 0);
    tick();
    check("st_res_en1", alu_en, 0);
    lsb_result = 1'b1; lsb_result_rob_pos = 4'd5; lsb_result_val = 32'h56;
    tick(); clr_bus();
    tick();
    check("st_p3_en", alu_en, 1);
    check("st_p3_rob", alu_rob_pos, 3);
    check("st_p3_val1", alu_val1, 32'h56);
    tick();
    check("st_end", alu_en, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
